// File: rtl/cic_pkg.sv
// Shared types for the convolution image accelerator: memory selects,
// engine opcodes and the layer-sequencer phase encoding.
package cic_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 20;

    typedef enum logic [2:0] {
        NSEL = 3'd0,
        L0K0 = 3'd1,
        L0K1 = 3'd2,
        L1K0 = 3'd3,
        L1K1 = 3'd4,
        L2F  = 3'd5
    } csel_e;

    localparam logic [1:0] OP_CONV = 2'd0;
    localparam logic [1:0] OP_POOL = 2'd1;
    localparam logic [1:0] OP_FLAT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV0,
        ST_CONV1,
        ST_POOL0,
        ST_POOL1,
        ST_FLAT,
        ST_FIN
    } phase_e;

    function automatic phase_e next_phase(input phase_e cur);
        phase_e nxt;
        unique case (cur)
            ST_CONV0: nxt = ST_CONV1;
            ST_CONV1: nxt = ST_POOL0;
            ST_POOL0: nxt = ST_POOL1;
            ST_POOL1: nxt = ST_FLAT;
            ST_FLAT:  nxt = ST_FIN;
            default:  nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/cic_port_arb.sv
// Result-memory port arbiter: combinational grant of the active engine's
// request, csel mapping and the registered memory-port stage.
module cic_port_arb
    import cic_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          act,
    input  logic [1:0]    op,
    input  logic          kernel,
    input  logic          req_rd,
    input  logic [AW-1:0] req_raddr,
    input  logic          req_src,
    input  logic          req_wr,
    input  logic [AW-1:0] req_waddr,
    input  logic [DW-1:0] req_wdata,
    output logic          gnt_rd,
    output logic          gnt_wr,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    logic          crd_q, crd_d;
    logic          cwr_q, cwr_d;
    csel_e         csel_q, csel_d;
    logic [AW-1:0] caddr_rd_q, caddr_rd_d;
    logic [AW-1:0] caddr_wr_q, caddr_wr_d;
    logic [DW-1:0] cdata_wr_q, cdata_wr_d;

    // Reads win over writes; the engine keeps a stalled write asserted.
    always_comb begin
        gnt_rd = 1'b0;
        gnt_wr = 1'b0;
        if (act) begin
            if (op == OP_CONV) begin
                gnt_wr = req_wr;
            end else begin
                gnt_rd = req_rd;
                gnt_wr = req_wr && !req_rd;
            end
        end
    end

    always_comb begin
        csel_d = NSEL;
        if (gnt_rd) begin
            if (op == OP_POOL) csel_d = kernel ? L0K1 : L0K0;
            else               csel_d = req_src ? L1K1 : L1K0;
        end else if (gnt_wr) begin
            unique case (op)
                OP_CONV: csel_d = kernel ? L0K1 : L0K0;
                OP_POOL: csel_d = kernel ? L1K1 : L1K0;
                default: csel_d = L2F;
            endcase
        end
    end

    always_comb begin
        crd_d      = gnt_rd;
        cwr_d      = gnt_wr;
        caddr_rd_d = gnt_rd ? req_raddr : caddr_rd_q;
        caddr_wr_d = gnt_wr ? req_waddr : caddr_wr_q;
        cdata_wr_d = gnt_wr ? req_wdata : cdata_wr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            csel_q     <= NSEL;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
        end else begin
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            csel_q     <= csel_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
        end
    end

    assign crd      = crd_q;
    assign cwr      = cwr_q;
    assign csel     = csel_q;
    assign caddr_rd = caddr_rd_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Layer scheduler: runs conv0/conv1/pool0/pool1/flatten engines in turn
// and owns the shared result-memory port through cic_port_arb.
module cnn_layer_sequencer
    import cic_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    output logic          eng_start,
    output logic [1:0]    eng_op,
    output logic          eng_kernel,
    input  logic          eng_done,
    input  logic          req_rd,
    input  logic [AW-1:0] req_raddr,
    input  logic          req_src,
    input  logic          req_wr,
    input  logic [AW-1:0] req_waddr,
    input  logic [DW-1:0] req_wdata,
    output logic          gnt_rd,
    output logic          gnt_wr,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    phase_e state_q, state_d;
    logic   wait_q, wait_d;
    logic   in_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // wait_q=0 is the one-cycle START sub-step of a phase.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            ST_IDLE: begin
                wait_d = 1'b0;
                if (ready) state_d = ST_CONV0;
            end
            ST_FIN: begin
                wait_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else if (eng_done) begin
                    wait_d  = 1'b0;
                    state_d = next_phase(state_q);
                end
            end
        endcase
    end

    always_comb begin
        in_phase   = 1'b1;
        eng_op     = OP_CONV;
        eng_kernel = 1'b0;
        unique case (state_q)
            ST_CONV0: ;
            ST_CONV1: eng_kernel = 1'b1;
            ST_POOL0: eng_op = OP_POOL;
            ST_POOL1: begin
                eng_op     = OP_POOL;
                eng_kernel = 1'b1;
            end
            ST_FLAT:  eng_op = OP_FLAT;
            default:  in_phase = 1'b0;
        endcase
        busy      = (state_q != ST_IDLE);
        eng_start = in_phase && !wait_q;
    end

    cic_port_arb #(
        .AW(AW),
        .DW(DW)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .act       (in_phase && wait_q),
        .op        (eng_op),
        .kernel    (eng_kernel),
        .req_rd    (req_rd),
        .req_raddr (req_raddr),
        .req_src   (req_src),
        .req_wr    (req_wr),
        .req_waddr (req_waddr),
        .req_wdata (req_wdata),
        .gnt_rd    (gnt_rd),
        .gnt_wr    (gnt_wr),
        .crd       (crd),
        .caddr_rd  (caddr_rd),
        .cwr       (cwr),
        .caddr_wr  (caddr_wr),
        .cdata_wr  (cdata_wr),
        .csel      (csel)
    );

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: directed schedule/port cases plus
// random stimulus against a phase-list reference model.
module tb_cnn_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        busy;
    logic        eng_start;
    logic [1:0]  eng_op;
    logic        eng_kernel;
    logic        eng_done;
    logic        req_rd;
    logic [11:0] req_raddr;
    logic        req_src;
    logic        req_wr;
    logic [11:0] req_waddr;
    logic [19:0] req_wdata;
    logic        gnt_rd;
    logic        gnt_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic [2:0]  csel;

    always #5 clk = ~clk;

    cnn_layer_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .ready      (ready),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_op     (eng_op),
        .eng_kernel (eng_kernel),
        .eng_done   (eng_done),
        .req_rd     (req_rd),
        .req_raddr  (req_raddr),
        .req_src    (req_src),
        .req_wr     (req_wr),
        .req_waddr  (req_waddr),
        .req_wdata  (req_wdata),
        .gnt_rd     (gnt_rd),
        .gnt_wr     (gnt_wr),
        .crd        (crd),
        .caddr_rd   (caddr_rd),
        .cwr        (cwr),
        .caddr_wr   (caddr_wr),
        .cdata_wr   (cdata_wr),
        .csel       (csel)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: ph 0 = idle, 1..5 = the five phases in order, 6 = finish.
    int          m_ph;
    bit          m_wait;
    bit          m_crd, m_cwr;
    int          m_csel;
    logic [11:0] m_ra, m_wa;
    logic [19:0] m_wd;
    bit          e_gr, e_gw;

    int n_starts;
    int st_op[16];
    int st_k[16];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_op();
        return (m_ph >= 1 && m_ph <= 5) ? (m_ph - 1) / 2 : 0;
    endfunction

    function automatic int m_k();
        return (m_ph >= 1 && m_ph <= 4) ? (m_ph - 1) % 2 : 0;
    endfunction

    task automatic check_outs();
        check("busy", busy, m_ph != 0);
        check("eng_start", eng_start, m_ph >= 1 && m_ph <= 5 && !m_wait);
        check("eng_op", eng_op, m_op());
        check("eng_kernel", eng_kernel, m_k());
        check("crd", crd, m_crd);
        check("cwr", cwr, m_cwr);
        check("csel", csel, m_csel);
        check("caddr_rd", caddr_rd, m_ra);
        check("caddr_wr", caddr_wr, m_wa);
        check("cdata_wr", cdata_wr, m_wd);
        if (eng_start && n_starts < 16) begin
            st_op[n_starts] = eng_op;
            st_k[n_starts]  = eng_kernel;
        end
        if (eng_start) n_starts++;
    endtask

    task automatic m_reset();
        m_ph = 0; m_wait = 0;
        m_crd = 0; m_cwr = 0; m_csel = 0;
        m_ra = '0; m_wa = '0; m_wd = '0;
    endtask

    // Called at a negedge; leaves the bench at the next negedge.
    task automatic step(input bit rdy, input bit dn, input bit rd,
                        input logic [11:0] ra, input bit src, input bit wr,
                        input logic [11:0] wa, input logic [19:0] wd);
        ready = rdy; eng_done = dn;
        req_rd = rd; req_raddr = ra; req_src = src;
        req_wr = wr; req_waddr = wa; req_wdata = wd;
        e_gr = 0; e_gw = 0;
        if (m_ph >= 1 && m_ph <= 5 && m_wait) begin
            if (m_op() == 0) e_gw = wr;
            else begin
                e_gr = rd;
                e_gw = wr && !rd;
            end
        end
        #1;
        check("gnt_rd", gnt_rd, e_gr);
        check("gnt_wr", gnt_wr, e_gw);
        @(posedge clk);
        m_crd = e_gr; m_cwr = e_gw; m_csel = 0;
        if (e_gr) begin
            m_ra = ra;
            m_csel = (m_op() == 1) ? 1 + m_k() : 3 + int'(src);
        end else if (e_gw) begin
            m_wa = wa; m_wd = wd;
            m_csel = (m_op() == 0) ? 1 + m_k() :
                     (m_op() == 1) ? 3 + m_k() : 5;
        end
        if (m_ph == 0) begin
            if (rdy) begin m_ph = 1; m_wait = 0; end
        end else if (m_ph == 6) begin
            m_ph = 0;
        end else if (!m_wait) begin
            m_wait = 1;
        end else if (dn) begin
            m_ph++; m_wait = 0;
        end
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle_step(input bit dn);
        step(0, dn, 0, '0, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        reset = 1; ready = 0; eng_done = 0;
        req_rd = 0; req_wr = 0;
        #1;
        m_reset();
        check_outs();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        check_outs();
    endtask

    // From idle, reach the WAIT sub-step of phase tgt.
    task automatic goto_wait(input int tgt);
        step(1, 0, 0, '0, 0, 0, '0, '0);
        for (int i = 0; i < 12; i++) begin
            idle_step(0);
            if (m_ph == tgt) break;
            idle_step(1);
        end
        check("goto_wait", m_ph, tgt);
    endtask

    initial begin
        int cnt;
        int ops[5] = '{0, 0, 1, 1, 2};
        int ks[5]  = '{0, 1, 0, 1, 0};
        bit seen;
        reset = 1; ready = 0; eng_done = 0;
        req_rd = 0; req_raddr = '0; req_src = 0;
        req_wr = 0; req_waddr = '0; req_wdata = '0;
        m_reset();
        @(negedge clk);
        do_reset();

        // Full run with a stub engine finishing 10 cycles after start.
        n_starts = 0; cnt = -1; seen = 0;
        step(1, 0, 0, '0, 0, 0, '0, '0);
        for (int i = 0; i < 200; i++) begin
            if (eng_start) cnt = 0;
            else if (cnt >= 0) cnt++;
            if (busy) seen = 1;
            if (seen && !busy) break;
            idle_step(cnt == 10);
        end
        check("run_ended", busy, 0);
        check("n_starts", n_starts, 5);
        for (int i = 0; i < 5; i++) begin
            check("seq_op", st_op[i], ops[i]);
            check("seq_k", st_k[i], ks[i]);
        end

        // Conv kernel 1 write, read never granted.
        goto_wait(2);
        step(0, 0, 1, 12'h123, 0, 1, 12'hFFF, 20'h12345);
        check("c1_cwr", cwr, 1);
        check("c1_crd", crd, 0);
        check("c1_addr", caddr_wr, 12'hFFF);
        check("c1_data", cdata_wr, 20'h12345);
        check("c1_csel", csel, 3'b010);
        // Spurious ready in conv1 wait.
        n_starts = 0;
        step(1, 0, 0, '0, 0, 0, '0, '0);
        check("spur_rdy_k", eng_kernel, 1);
        check("spur_rdy_st", n_starts, 0);

        // Pool kernel 0: read beats write, then write lands.
        idle_step(1);
        step(0, 1, 0, '0, 0, 0, '0, '0);
        check("spur_done_st", eng_start, 0);
        check("spur_done_op", eng_op, 1);
        check("spur_done_k", eng_kernel, 0);
        check("spur_done_n", n_starts, 1);
        step(0, 0, 1, 12'h040, 0, 1, 12'h010, 20'h00ABC);
        check("p0_crd", crd, 1);
        check("p0_cwr", cwr, 0);
        check("p0_csel", csel, 3'b001);
        check("p0_ra", caddr_rd, 12'h040);
        step(0, 0, 0, 12'h040, 0, 1, 12'h010, 20'h00ABC);
        check("p0_cwr2", cwr, 1);
        check("p0_csel2", csel, 3'b011);
        check("p0_wa", caddr_wr, 12'h010);

        // Reset during pool1 wait.
        idle_step(1);
        idle_step(0);
        step(0, 0, 1, 12'h7, 0, 0, '0, '0);
        check("pre_rst_busy", busy, 1);
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_csel", csel, 0);
        check("rst_crd", crd | cwr, 0);
        for (int i = 0; i < 3; i++) idle_step(1);
        check("rst_idle", busy, 0);
        step(1, 0, 0, '0, 0, 0, '0, '0);
        check("restart_st", eng_start, 1);
        check("restart_op", eng_op, 0);
        check("restart_k", eng_kernel, 0);
        do_reset();

        // Flatten reads by source and write to L2.
        goto_wait(5);
        step(0, 0, 1, 12'h100, 1, 0, '0, '0);
        check("fl_csel_rd1", csel, 3'b100);
        step(0, 0, 1, 12'h101, 0, 1, 12'h222, 20'h1);
        check("fl_csel_rd0", csel, 3'b011);
        step(0, 0, 0, '0, 0, 1, 12'h7FF, 20'hFACE0);
        check("fl_csel_wr", csel, 3'b101);
        check("fl_addr_wr", caddr_wr, 12'h7FF);
        idle_step(1);
        check("fin_busy", busy, 1);
        idle_step(0);
        check("fin_done", busy, 0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0,
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 1) == 1,
                     12'($urandom), 1'($urandom),
                     $urandom_range(0, 1) == 1,
                     12'($urandom), 20'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
